ni_packet_injector: RTL and testbench

- Network-interface transmit engine that turns a packet request plus a payload word stream into header, body and tail flits.
- Drives a router Local input port: TX feeds the router's L_RX, RTS feeds L_DRTS, and DCTS is driven by the router's L_CTS.
- One packet in flight at a time. Flits are held stable under back-pressure and carry even parity in bit 0.

---
 rtl/ni_packet_injector.sv | 109 ++++++++++
 tb/tb_ni_packet_injector.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packet_injector.sv
// Network-interface transmit engine: turns a packet request plus a payload word stream
// into header/body/tail flits for a router Local input port, one packet in flight.
module ni_packet_injector #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AXIS       = 4,
   parameter int unsigned LEN_W      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXIS-1:0]       cur_addr,
   input  logic                  pkt_req,
   input  logic [AXIS-1:0]       pkt_dst,
   input  logic [LEN_W-1:0]      pkt_len,
   output logic                  pkt_ack,
   output logic                  pkt_err,
   input  logic [27:0]           pl_data,
   input  logic                  pl_valid,
   output logic                  pl_ready,
   output logic [DATA_WIDTH-1:0] TX,
   output logic                  RTS,
   input  logic                  DCTS,
   output logic                  busy,
   output logic                  pkt_done,
   output logic [15:0]           pkt_cnt
);

   localparam int unsigned PL_W = DATA_WIDTH - 4;

   typedef enum logic [1:0] {StIdle, StHead, StPayload} state_t;

   state_t           state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] rem_q;
   logic [7:0]       pkt_id_q;

   // Type field on top, even parity over everything above bit 0.
   function automatic logic [DATA_WIDTH-1:0] mk_flit(input logic [2:0]      typ,
                                                    input logic [PL_W-1:0] field);
      logic [DATA_WIDTH-1:0] f;
      f    = {typ, field, 1'b0};
      f[0] = ^f[DATA_WIDTH-1:1];
      return f;
   endfunction

   logic [PL_W-1:0] hdr_field;
   assign hdr_field = {pkt_len, pkt_dst, cur_addr, pkt_id_q};

   // rem_q==0 means the tail is already loaded, so no further word may be taken.
   assign pl_ready = (state_q == StPayload) && pl_valid && (rem_q != '0) && (!RTS || DCTS);
   assign busy     = (state_q != StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         len_q    <= '0;
         rem_q    <= '0;
         pkt_id_q <= '0;
         TX       <= '0;
         RTS      <= 1'b0;
         pkt_ack  <= 1'b0;
         pkt_err  <= 1'b0;
         pkt_done <= 1'b0;
         pkt_cnt  <= '0;
      end else begin
         pkt_ack  <= 1'b0;
         pkt_err  <= 1'b0;
         pkt_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pkt_req) begin
                  if (pkt_len >= LEN_W'(2)) begin
                     pkt_ack <= 1'b1;
                     len_q   <= pkt_len;
                     TX      <= mk_flit(3'b001, hdr_field);
                     RTS     <= 1'b1;
                     state_q <= StHead;
                  end else begin
                     pkt_err <= 1'b1;
                  end
               end
            end
            StHead: begin
               if (DCTS) begin
                  rem_q    <= len_q - LEN_W'(1);
                  pkt_id_q <= pkt_id_q + 8'd1;
                  RTS      <= 1'b0;
                  state_q  <= StPayload;
               end
            end
            StPayload: begin
               if (pl_ready) begin
                  TX    <= mk_flit((rem_q == LEN_W'(1)) ? 3'b100 : 3'b010, pl_data);
                  RTS   <= 1'b1;
                  rem_q <= rem_q - LEN_W'(1);
               end else if (RTS && DCTS) begin
                  RTS <= 1'b0;
                  if (rem_q == '0) begin
                     state_q  <= StIdle;
                     pkt_done <= 1'b1;
                     pkt_cnt  <= pkt_cnt + 16'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_packet_injector.sv
// Scoreboard bench for ni_packet_injector: stimulus pushes expected flits, a monitor pops
// and compares on every transfer; payload and DCTS are randomised.
module tb_ni_packet_injector;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cur_addr;
   logic        pkt_req;
   logic [3:0]  pkt_dst;
   logic [11:0] pkt_len;
   logic        pkt_ack, pkt_err;
   logic [27:0] pl_data;
   logic        pl_valid, pl_ready;
   logic [31:0] TX;
   logic        RTS, DCTS, busy, pkt_done;
   logic [15:0] pkt_cnt;

   always #5 clk = ~clk;

   ni_packet_injector #(.DATA_WIDTH(32), .AXIS(4), .LEN_W(12)) dut (
      .clk(clk), .rst(rst), .cur_addr(cur_addr), .pkt_req(pkt_req), .pkt_dst(pkt_dst),
      .pkt_len(pkt_len), .pkt_ack(pkt_ack), .pkt_err(pkt_err), .pl_data(pl_data),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .TX(TX), .RTS(RTS), .DCTS(DCTS),
      .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
   );

   logic [31:0] exp_q[$];
   logic [27:0] pl_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_done  = 0;
   int          n_xfer  = 0;
   logic [7:0]  m_id    = 8'd0;
   logic [15:0] m_cnt   = 16'd0;
   int          dcts_mode = 1;   // 0 random, 1 always ready, 2 stalled
   bit          pv_en   = 1'b1;
   bit          pv_rand = 1'b0;

   function automatic logic [31:0] flit(input logic [2:0] typ, input logic [27:0] f);
      logic [31:0] w;
      w    = {typ, f, 1'b0};
      w[0] = ^w[31:1];
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait expired, got no event expected one (t=%0t)", name, $time);
   endtask

   // Payload source and router back-pressure, driven on the falling edge.
   always begin
      @(negedge clk);
      DCTS = (dcts_mode == 1) ? 1'b1 : (dcts_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (pv_en && pl_q.size() > 0 && (!pv_rand || $urandom_range(0, 3) != 0)) begin
         pl_valid = 1'b1;
         pl_data  = pl_q[0];
      end else begin
         pl_valid = 1'b0;
         pl_data  = 28'($urandom);
      end
      #1;
      if (pl_ready && pl_valid) void'(pl_q.pop_front());
   end

   // Monitor: values sampled here are what the next rising edge transfers.
   logic        prev_rts = 1'b0, prev_dcts = 1'b0, prev_tail = 1'b0;
   logic [31:0] prev_tx  = '0;
   logic [31:0] mon_e;
   logic        mon_tail;
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         prev_rts  = 1'b0;
         prev_dcts = 1'b0;
         prev_tail = 1'b0;
      end else begin
         mon_tail = 1'b0;
         if (prev_rts && !prev_dcts) begin
            check("hold_rts", {31'd0, RTS}, 32'd1);
            check("hold_tx", TX, prev_tx);
         end
         if (RTS && !DCTS) check("ready_under_stall", {31'd0, pl_ready}, 32'd0);
         if (!busy && pl_valid) check("ready_outside_payload", {31'd0, pl_ready}, 32'd0);
         if (pkt_done || prev_tail) check("done_pulse", {31'd0, pkt_done}, {31'd0, prev_tail});
         if (pkt_done) n_done++;
         if (RTS && DCTS) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_flit: got %h expected none", TX);
            end else begin
               mon_e = exp_q.pop_front();
               check("flit", TX, mon_e);
               mon_tail = (mon_e[31:29] == 3'b100);
            end
         end
         prev_rts  = RTS;
         prev_dcts = DCTS;
         prev_tx   = TX;
         prev_tail = mon_tail;
      end
   end

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         #3;
         if (exp_q.size() == 0 && !busy) break;
      end
      if (i == 20000) timeout(name);
   endtask

   task automatic wait_qsize(input int sz, input string name);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (exp_q.size() <= sz) break;
         @(negedge clk);
         #3;
      end
      if (i == 2000) timeout(name);
   endtask

   task automatic send_req(input logic [11:0] len, input logic [3:0] dst);
      int i;
      @(posedge clk);
      #1;
      pkt_req = 1'b1;
      pkt_len = len;
      pkt_dst = dst;
      for (i = 0; i < 20000; i++) begin
         @(posedge clk);
         #1;
         if (pkt_ack) break;
      end
      if (i == 20000) timeout("pkt_ack");
      else check("header_rts_with_ack", {31'd0, RTS}, 32'd1);
      pkt_req = 1'b0;
      pkt_len = 12'($urandom);
      pkt_dst = 4'($urandom);
   endtask

   task automatic issue(input logic [11:0] len, input logic [3:0] dst);
      logic [27:0] w;
      exp_q.push_back(flit(3'b001, {len, dst, cur_addr, m_id}));
      m_id++;
      m_cnt++;
      for (int i = 1; i < int'(len); i++) begin
         w = 28'($urandom);
         pl_q.push_back(w);
         exp_q.push_back(flit((i == int'(len) - 1) ? 3'b100 : 3'b010, w));
      end
      send_req(len, dst);
   endtask

   task automatic reject(input logic [11:0] len);
      @(posedge clk);
      #1;
      pkt_req = 1'b1;
      pkt_len = len;
      @(posedge clk);
      #1;
      check("err_pulse", {31'd0, pkt_err}, 32'd1);
      check("err_no_ack", {31'd0, pkt_ack}, 32'd0);
      check("err_no_rts", {31'd0, RTS}, 32'd0);
      check("err_not_busy", {31'd0, busy}, 32'd0);
      pkt_req = 1'b0;
      @(posedge clk);
      #1;
      check("err_one_cycle", {31'd0, pkt_err}, 32'd0);
   endtask

   int xfer_base;

   initial begin
      rst = 1'b1; cur_addr = 4'h0; pkt_req = 1'b0; pkt_dst = '0; pkt_len = '0;
      pl_data = '0; pl_valid = 1'b0; DCTS = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", TX, 32'd0);
      check("rst_rts", {31'd0, RTS}, 32'd0);
      check("rst_ack", {31'd0, pkt_ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, pl_ready}, 32'd0);
      check("rst_cnt", {16'd0, pkt_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Known-answer packet with DCTS held high.
      exp_q.push_back(32'h2006_6001);
      exp_q.push_back(32'h4000_0002);
      exp_q.push_back(32'h8000_0007);
      pl_q.push_back(28'h1);
      pl_q.push_back(28'h3);
      m_id++; m_cnt++;
      send_req(12'd3, 4'd3);
      wait_idle("kat_idle");
      check("kat_done_count", n_done, 32'd1);
      check("kat_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

      // Same packet with the body stalled for 5 cycles.
      exp_q.push_back(flit(3'b001, {12'd3, 4'd3, cur_addr, m_id}));
      exp_q.push_back(32'h4000_0002);
      exp_q.push_back(32'h8000_0007);
      pl_q.push_back(28'h1);
      pl_q.push_back(28'h3);
      m_id++; m_cnt++;
      send_req(12'd3, 4'd3);
      wait_qsize(2, "stall_header");
      dcts_mode = 2;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #3;
         check("stall_tx", TX, 32'h4000_0002);
         check("stall_rts", {31'd0, RTS}, 32'd1);
         check("stall_ready", {31'd0, pl_ready}, 32'd0);
      end
      dcts_mode = 1;
      wait_idle("stall_idle");
      check("stall_done_count", n_done, 32'd2);

      reject(12'd1);
      reject(12'd0);

      // Payload gap between header and tail.
      pv_en = 1'b0;
      issue(12'd2, 4'h9);
      wait_qsize(1, "gap_header");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #3;
         check("gap_rts_low", {31'd0, RTS}, 32'd0);
      end
      pv_en = 1'b1;
      wait_idle("gap_idle");

      // Asynchronous reset in the middle of a long body.
      issue(12'd10, 4'h5);
      wait_qsize(6, "abort_body");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_rts", {31'd0, RTS}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_tx", TX, 32'd0);
      check("abort_cnt", {16'd0, pkt_cnt}, 32'd0);
      exp_q.delete();
      pl_q.delete();
      m_id = 8'd0; m_cnt = 16'd0; n_done = 0;
      cur_addr = 4'hA;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(12'd3, 4'h6);
      wait_idle("post_abort_idle");
      check("post_abort_cnt", {16'd0, pkt_cnt}, 32'd1);

      // Randomised traffic, back-pressure and payload gaps, plus a maximum-length packet.
      dcts_mode = 0;
      pv_rand   = 1'b1;
      for (int k = 0; k < 30; k++) begin
         logic [11:0] l;
         l = 12'($urandom_range(0, 9));
         if (l < 12'd2) begin
            wait_idle("rand_pre_reject");
            reject(l);
         end else begin
            issue(l, 4'($urandom));
         end
      end
      issue(12'd4095, 4'($urandom));
      wait_idle("rand_idle");
      check("rand_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, m_cnt});
      check("rand_done_count", n_done, {16'd0, m_cnt});

      // 256 back-to-back minimum packets: packet id wraps.
      dcts_mode = 1;
      pv_rand   = 1'b0;
      xfer_base = n_xfer;
      for (int k = 0; k < 256; k++) issue(12'd2, 4'($urandom));
      wait_idle("b2b_idle");
      check("b2b_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, m_cnt});
      check("b2b_transfers", n_xfer - xfer_base, 32'd512);
      check("payload_drained", pl_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
